alarm_controller: RTL and testbench

- Initiator side of the alarm-trigger interface: holds the user-set alarm time, compares it against the running clock time, and issues single-cycle `alarm_trigger` pulses to the downstream alarm-signal driver.
- The driver holds its output for a fixed period per pulse; this block decides when pulses occur.
- Pulse sources: first match, periodic re-ring, snooze expiry.
- Also handles stop requests.
- Sits between the timekeeping counter and the alarm display/buzzer driver.

---
 rtl/alarm_controller.sv | 148 ++++++++++++++
 tb/tb_alarm_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm time storage, match detection and trigger pulse sequencing
module alarm_controller #(
  parameter int RETRIGGER_CYCLES = 10000000,
  parameter int RING_REPEATS     = 6,
  parameter int SNOOZE_CYCLES    = 300000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic       alarm_enable,
  input  logic       set_mode,
  input  logic       btn_hour_inc,
  input  logic       btn_min_inc,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       alarm_trigger,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing
);

  localparam int RW = $clog2(RETRIGGER_CYCLES) + 1;
  localparam int NW = $clog2(RING_REPEATS) + 1;
  localparam int SW = $clog2(SNOOZE_CYCLES) + 1;

  localparam logic [RW-1:0] RT_LOAD  = RW'(RETRIGGER_CYCLES - 1);
  localparam logic [NW-1:0] REP_LOAD = NW'(RING_REPEATS - 1);
  localparam logic [SW-1:0] SN_LOAD  = SW'(SNOOZE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  state_t        state, state_n;
  logic [RW-1:0] retrig_cnt, retrig_n;
  logic [NW-1:0] repeats_left, repeats_n;
  logic [SW-1:0] snooze_cnt, snooze_n;
  logic          fire;
  logic          match, match_d, match_rise;
  logic [4:0]    hours_n;
  logic [5:0]    minutes_n;
  logic          armed_n, ringing_n, snoozing_n;

  assign match      = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes) &&
                      (cur_seconds == 6'd0);
  assign match_rise = match && !match_d;

  always_comb begin
    hours_n   = alarm_hours;
    minutes_n = alarm_minutes;
    if (set_mode && btn_hour_inc)
      hours_n = (alarm_hours == 5'd23) ? 5'd0 : alarm_hours + 5'd1;
    if (set_mode && btn_min_inc)
      minutes_n = (alarm_minutes == 6'd59) ? 6'd0 : alarm_minutes + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      retrig_cnt    <= '0;
      repeats_left  <= '0;
      snooze_cnt    <= '0;
      match_d       <= 1'b0;
      alarm_trigger <= 1'b0;
      alarm_hours   <= 5'd0;
      alarm_minutes <= 6'd0;
      armed         <= 1'b0;
      ringing       <= 1'b0;
      snoozing      <= 1'b0;
    end else begin
      state         <= state_n;
      retrig_cnt    <= retrig_n;
      repeats_left  <= repeats_n;
      snooze_cnt    <= snooze_n;
      match_d       <= match;
      alarm_trigger <= fire;
      alarm_hours   <= hours_n;
      alarm_minutes <= minutes_n;
      armed         <= armed_n;
      ringing       <= ringing_n;
      snoozing      <= snoozing_n;
    end
  end

  always_comb begin
    state_n   = state;
    retrig_n  = retrig_cnt;
    repeats_n = repeats_left;
    snooze_n  = snooze_cnt;
    fire      = 1'b0;
    if (!alarm_enable) begin
      state_n = IDLE;
    end else if (set_mode) begin
      state_n = ARMED;
    end else begin
      case (state)
        IDLE: state_n = ARMED;
        ARMED: begin
          if (match_rise) begin
            state_n   = RINGING;
            fire      = 1'b1;
            repeats_n = REP_LOAD;
            retrig_n  = RT_LOAD;
          end
        end
        RINGING: begin
          if (stop_btn) begin
            state_n = ARMED;
          end else if (snooze_btn) begin
            state_n  = SNOOZE;
            snooze_n = SN_LOAD;
          end else if (retrig_cnt != '0) begin
            retrig_n = retrig_cnt - 1'b1;
          end else if (repeats_left == '0) begin
            state_n = ARMED;
          end else if (!alarm_trigger) begin
            // holding at zero while a pulse is still high keeps a low gap when RETRIGGER_CYCLES is 1
            fire      = 1'b1;
            repeats_n = repeats_left - 1'b1;
            retrig_n  = RT_LOAD;
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_n = ARMED;
          end else if (snooze_cnt != '0) begin
            snooze_n = snooze_cnt - 1'b1;
          end else begin
            state_n   = RINGING;
            fire      = 1'b1;
            repeats_n = REP_LOAD;
            retrig_n  = RT_LOAD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    armed_n    = (state_n == ARMED);
    ringing_n  = (state_n == RINGING);
    snoozing_n = (state_n == SNOOZE);
  end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed plus random stimulus against an episode-schedule model
module tb_alarm_controller;
  localparam int RT = 4;
  localparam int RP = 3;
  localparam int SN = 10;

  localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic       alarm_enable, set_mode, btn_hour_inc, btn_min_inc, stop_btn, snooze_btn;
  logic       alarm_trigger;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       armed, ringing, snoozing;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  int edge_no = 0;
  int mode = M_OFF;
  int ring_start = 0;
  int snz_start = 0;
  int mh = 0;
  int mm = 0;
  bit prev_match = 1'b0;
  bit exp_trig = 1'b0;

  alarm_controller #(
    .RETRIGGER_CYCLES(RT),
    .RING_REPEATS(RP),
    .SNOOZE_CYCLES(SN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cur_hours(cur_hours),
    .cur_minutes(cur_minutes),
    .cur_seconds(cur_seconds),
    .alarm_enable(alarm_enable),
    .set_mode(set_mode),
    .btn_hour_inc(btn_hour_inc),
    .btn_min_inc(btn_min_inc),
    .stop_btn(stop_btn),
    .snooze_btn(snooze_btn),
    .alarm_trigger(alarm_trigger),
    .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes),
    .armed(armed),
    .ringing(ringing),
    .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A ring episode is a schedule: pulses every RT edges from its start, RP of them,
  // returning to armed RP*RT edges after the start; snooze restarts the schedule SN edges later.
  task automatic model();
    bit m, rise;
    edge_no++;
    exp_trig = 1'b0;
    if (!rst) begin
      mode = M_OFF;
      mh = 0;
      mm = 0;
      prev_match = 1'b0;
    end else begin
      m = (int'(cur_hours) == mh) && (int'(cur_minutes) == mm) && (cur_seconds == 0);
      rise = m && !prev_match;
      prev_match = m;
      if (set_mode && btn_hour_inc) mh = (mh + 1) % 24;
      if (set_mode && btn_min_inc) mm = (mm + 1) % 60;
      if (!alarm_enable) mode = M_OFF;
      else if (set_mode) mode = M_ARMED;
      else if (mode == M_OFF) mode = M_ARMED;
      else if (stop_btn && (mode == M_RING || mode == M_SNZ)) mode = M_ARMED;
      else if (snooze_btn && mode == M_RING) begin
        mode = M_SNZ;
        snz_start = edge_no;
      end else if (mode == M_ARMED && rise) begin
        mode = M_RING;
        ring_start = edge_no;
        exp_trig = 1'b1;
      end else if (mode == M_RING) begin
        if (edge_no - ring_start == RP * RT) mode = M_ARMED;
        else if ((edge_no - ring_start) % RT == 0) exp_trig = 1'b1;
      end else if (mode == M_SNZ && edge_no - snz_start == SN) begin
        mode = M_RING;
        ring_start = edge_no;
        exp_trig = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("trigger", alarm_trigger, exp_trig);
    chk("alarm_hours", alarm_hours, mh);
    chk("alarm_minutes", alarm_minutes, mm);
    chk("armed", armed, mode == M_ARMED);
    chk("ringing", ringing, mode == M_RING);
    chk("snoozing", snoozing, mode == M_SNZ);
    if (alarm_trigger) pulses++;
    btn_hour_inc = 1'b0;
    btn_min_inc = 1'b0;
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    alarm_enable = 1'b0;
    set_mode = 1'b0;
    btn_hour_inc = 1'b0;
    btn_min_inc = 1'b0;
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    cur_hours = 5'd0;
    cur_minutes = 6'd0;
    cur_seconds = 6'd5;

    step();
    step();
    chk("reset_trigger", alarm_trigger, 0);
    chk("reset_time", {alarm_hours, alarm_minutes}, 0);
    rst = 1'b1;

    set_mode = 1'b1;
    repeat (24) begin btn_hour_inc = 1'b1; step(); end
    chk("hour_wrap", alarm_hours, 0);
    repeat (3) begin btn_hour_inc = 1'b1; step(); end
    repeat (61) begin btn_min_inc = 1'b1; step(); end
    chk("set_hours", alarm_hours, 3);
    chk("set_minutes", alarm_minutes, 1);
    set_mode = 1'b0;
    btn_hour_inc = 1'b1;
    btn_min_inc = 1'b1;
    step();
    chk("locked_time", {alarm_hours, alarm_minutes}, {5'd3, 6'd1});

    alarm_enable = 1'b1;
    step();
    cur_hours = 5'd3;
    cur_minutes = 6'd1;
    cur_seconds = 6'd0;
    pulses = 0;
    repeat (20) step();
    chk("basic_pulses", pulses, 3);
    chk("basic_armed", armed, 1);
    cur_seconds = 6'd1;
    step();

    cur_seconds = 6'd0;
    step();
    repeat (3) step();
    stop_btn = 1'b1;
    step();
    chk("stop_no_pulse", alarm_trigger, 0);
    chk("stop_armed", armed, 1);
    cur_seconds = 6'd1;
    step();
    cur_seconds = 6'd0;
    step();
    step();
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    step();
    chk("both_snoozing", snoozing, 0);
    chk("both_armed", armed, 1);
    cur_seconds = 6'd1;
    step();

    cur_seconds = 6'd0;
    step();
    snooze_btn = 1'b1;
    step();
    chk("snooze_enter", snoozing, 1);
    repeat (4) step();
    snooze_btn = 1'b1;
    step();
    pulses = 0;
    repeat (20) step();
    chk("snooze_pulses", pulses, 3);
    cur_seconds = 6'd1;
    step();

    cur_seconds = 6'd0;
    step();
    step();
    alarm_enable = 1'b0;
    pulses = 0;
    step();
    chk("disable_idle", {armed, ringing, snoozing}, 0);
    repeat (5) step();
    alarm_enable = 1'b1;
    repeat (10) step();
    chk("disable_pulses", pulses, 0);
    cur_seconds = 6'd1;
    step();

    cur_seconds = 6'd0;
    step();
    snooze_btn = 1'b1;
    step();
    set_mode = 1'b1;
    step();
    chk("setmode_armed", armed, 1);
    cur_seconds = 6'd1;
    step();
    cur_seconds = 6'd0;
    pulses = 0;
    repeat (3) step();
    set_mode = 1'b0;
    repeat (5) step();
    chk("setmode_pulses", pulses, 0);
    cur_seconds = 6'd1;
    step();

    cur_seconds = 6'd0;
    step();
    rst = 1'b0;
    step();
    chk("midring_reset", {alarm_trigger, alarm_hours, alarm_minutes, armed, ringing, snoozing}, 0);
    rst = 1'b1;
    alarm_enable = 1'b0;
    pulses = 0;
    repeat (20) step();
    chk("reset_pulses", pulses, 0);

    repeat (3000) begin
      rst = ($urandom_range(0, 199) != 0);
      alarm_enable = ($urandom_range(0, 49) != 0);
      set_mode = ($urandom_range(0, 29) == 0);
      btn_hour_inc = ($urandom_range(0, 7) == 0);
      btn_min_inc = ($urandom_range(0, 7) == 0);
      stop_btn = ($urandom_range(0, 39) == 0);
      snooze_btn = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cur_seconds = 6'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) begin
          cur_hours = 5'(mh);
          cur_minutes = 6'(mm);
        end else begin
          cur_hours = 5'($urandom_range(0, 23));
          cur_minutes = 6'($urandom_range(0, 59));
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
